core_run_controller: RTL

//  Issues the level 'start' consumed by clock_corrector_module and sequences a compute run

---
 rtl/core_run_controller.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/core_run_controller.sv
// core_run_controller
//   Sequences one compute run across NUM_CORES matmul cores and drives the
//   level 'start' consumed by clock_corrector_module.
//   IDLE -> ARM (START_DELAY cycles) -> RUN (until every core reports done)
//   -> DRAIN (DRAIN_CYCLES cycles) -> DONE (one-cycle finished pulse) -> IDLE.
//   cycle_count reports the number of RUN cycles of the last run.
//   Optional feature macro: CORE_RUN_TIMEOUT_EN -- aborts RUN after MAX_CYCLES
//   cycles and raises the sticky timeout_err flag. Without it timeout_err is 0.

module core_run_controller #(
   parameter int NUM_CORES    = 4,
   parameter int START_DELAY  = 4,
   parameter int DRAIN_CYCLES = 2,
   parameter int CNT_W        = 16,
   parameter int MAX_CYCLES   = 60000
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 go,
   input  logic [NUM_CORES-1:0] core_done,
   output logic                 start,
   output logic [NUM_CORES-1:0] core_enable,
   output logic                 busy,
   output logic                 finished,
   output logic [CNT_W-1:0]     cycle_count,
   output logic                 timeout_err
);

   // One counter serves both ARM and DRAIN, so size it for the longer of the two.
   localparam int DLY_MAX = (START_DELAY > DRAIN_CYCLES) ? START_DELAY : DRAIN_CYCLES;
   localparam int DLY_W   = (DLY_MAX < 2) ? 1 : $clog2(DLY_MAX + 1);
   localparam logic [DLY_W-1:0] ARM_LAST   = DLY_W'(START_DELAY - 1);
   localparam logic [DLY_W-1:0] DRAIN_LAST = DLY_W'(DRAIN_CYCLES - 1);

   // Reject parameter sets the sequencing cannot honour.
   if (START_DELAY < 1 || DRAIN_CYCLES < 1 || MAX_CYCLES < 1 ||
       longint'(MAX_CYCLES) >= (longint'(1) << CNT_W)) begin : g_param_check
      $error("core_run_controller: illegal parameter combination");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t               state;
   logic [NUM_CORES-1:0] done_latch;
   logic [DLY_W-1:0]     dly_cnt;

   logic [NUM_CORES-1:0] done_next;
   logic                 all_done;
   logic [CNT_W-1:0]     count_inc;
   logic                 timeout_hit;

   // Latch view including this cycle's dones, so simultaneous dones end RUN at once.
   assign done_next = done_latch | core_done;
   assign all_done  = &done_next;

   // Saturating increment: a very long run pins at all-ones instead of wrapping.
   assign count_inc = (cycle_count == {CNT_W{1'b1}}) ? cycle_count
                                                     : cycle_count + CNT_W'(1);

`ifdef CORE_RUN_TIMEOUT_EN
   localparam logic [CNT_W-1:0] TIMEOUT_AT = CNT_W'(MAX_CYCLES - 1);
   assign timeout_hit = (cycle_count == TIMEOUT_AT);
`else
   assign timeout_hit = 1'b0;
`endif

   // Run sequencer: state, counters, done latches and every registered output.
   always_ff @(posedge clk) begin
      // NOTE: every register here, done latches included, is cleared by reset so
      // a reset in any state aborts the run within one cycle.
      if (reset) begin
         state       <= S_IDLE;
         done_latch  <= '0;
         dly_cnt     <= '0;
         start       <= 1'b0;
         core_enable <= '0;
         busy        <= 1'b0;
         finished    <= 1'b0;
         cycle_count <= '0;
         timeout_err <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every register sampling the values
         // from before this edge, regardless of statement order.
         finished <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (go) begin
                  state       <= S_ARM;
                  busy        <= 1'b1;
                  cycle_count <= '0;
                  done_latch  <= '0;
                  timeout_err <= 1'b0;
                  dly_cnt     <= '0;
               end
            end

            S_ARM: begin
               if (dly_cnt == ARM_LAST) begin
                  state       <= S_RUN;
                  start       <= 1'b1;
                  core_enable <= '1;
               end else begin
                  dly_cnt <= dly_cnt + DLY_W'(1);
               end
            end

            S_RUN: begin
               done_latch <= done_next;
               if (all_done) begin
                  // The cycle in which the last done arrives is still counted.
                  state       <= S_DRAIN;
                  cycle_count <= count_inc;
                  start       <= 1'b0;
                  core_enable <= '0;
                  dly_cnt     <= '0;
               end else if (timeout_hit) begin
                  // Abort leaves cycle_count at MAX_CYCLES-1.
                  state       <= S_DRAIN;
                  start       <= 1'b0;
                  core_enable <= '0;
                  dly_cnt     <= '0;
                  timeout_err <= 1'b1;
               end else begin
                  cycle_count <= count_inc;
                  core_enable <= ~done_next;
               end
            end

            S_DRAIN: begin
               if (dly_cnt == DRAIN_LAST) begin
                  state    <= S_DONE;
                  finished <= 1'b1;
               end else begin
                  dly_cnt <= dly_cnt + DLY_W'(1);
               end
            end

            S_DONE: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end

            default: begin
               state       <= S_IDLE;
               start       <= 1'b0;
               core_enable <= '0;
               busy        <= 1'b0;
            end
         endcase
      end
   end

endmodule
